qcl_mult_arbiter: RTL and testbench
===================================

// Module: qcl_mult_arbiter
// PURPOSE
//  Shares one pipelined multiplier (qcl_mult, latency_p 1..4) among num_req_p requesters.
//  Round-robin arbitration, valid/ready per requester, single tagged result channel with backpressure.
//  Sits between the requester engines and the multiplier instance; drives the multiplier's en_i/a_i/b_i.
//  Multiplier reset_i is driven externally with ~reset_n_i.
// PARAMETERS
//  width_p    "inv"  operand width; product is 2*width_p
//  num_req_p  4      number of requesters, >=2
//  latency_p  2      multiplier latency in cycles, 1..4; any other value -> $fatal at elaboration
//  id_width_lp       derived: `BSG_SAFE_CLOG2(num_req_p)
// PORTS
//  clk_i       in   1                  clock
//  reset_n_i   in   1                  one clock; reset is asynchronous and active-low
//  req_v_i     in   num_req_p          requester i has an operand pair
//  req_a_i     in   num_req_p*width_p  operand A, requester i at [i*width_p +: width_p]
//  req_b_i     in   num_req_p*width_p  operand B, same packing
//  req_ready_o out  num_req_p          one-hot; pair i is accepted this cycle when req_v_i[i] & req_ready_o[i]
//  mult_en_o   out  1                  to multiplier en_i; advances its whole pipeline
//  mult_a_o    out  width_p            to multiplier a_i
//  mult_b_o    out  width_p            to multiplier b_i
//  mult_p_i    in   2*width_p          from multiplier p_o
//  res_v_o     out  1                  result valid
//  res_p_o     out  2*width_p          product, = mult_p_i
//  res_id_o    out  id_width_lp        requester index that issued this product
//  res_ready_i in   1                  consumer accepts when res_v_o & res_ready_i
//  busy_o      out  1                  any valid operation inside the multiplier pipeline
// BEHAVIOUR
//  Reset (async assert, sync release): rr pointer=0, valid/id pipe cleared.
//   During reset: res_v_o=0, busy_o=0, req_ready_o=0, mult_en_o=0.
//  Tag pipe: latency_p stages of {v,id}; shifts only when mult_en_o=1, in lockstep with the multiplier.
//   res_v_o/res_id_o = last stage; busy_o = OR of all stage v bits.
//  Stall: stall = res_v_o & ~res_ready_i; mult_en_o = ~stall (out of reset).
//   Bubbles are not collapsed: a stall freezes the whole pipe, including empty stages.
//   While stalled: res_v_o, res_p_o and res_id_o are held stable; req_ready_o=0.
//  Arbitration: combinational.
//   Winner = first i with req_v_i[i]=1, scanning from the rr pointer upward and wrapping num_req_p-1 -> 0.
//   req_ready_o[winner] = mult_en_o. mult_a_o/mult_b_o = winner's operands (0 when no request).
//  Issue (mult_en_o & |req_v_i): stage0 <= {1, winner}; rr pointer <= winner+1, wrapping to 0.
//   No request: stage0 <= {0, x}; pointer unchanged.
//  Throughput: 1 issue/cycle with no stall. Latency accept -> res_v_o = latency_p cycles.
//  Results leave in issue order. A requester may drop req_v_i before it is accepted.
//  Simultaneous res accept + new issue in the same cycle is legal and is the steady state.
//  Reset mid-operation: in-flight products are discarded and never appear on res_v_o.
//  Products are unsigned: width_p x width_p -> 2*width_p, no truncation.
// TESTING
//  1 latency_p=2, width_p=8, req0 only, a=3, b=5, res_ready_i=1
//    -> accepted at cycle t; res_v_o=1, res_p_o=15, res_id_o=0 at t+2.
//  2 All 4 requesters valid continuously, res_ready_i=1
//    -> grants 0,1,2,3,0,... one per cycle; ids emerge in the same order latency_p later.
//  3 Pointer at 2, only req1 and req3 valid
//    -> grant 3 first, then 1; pointer wraps correctly.
//  4 Pipe full, res_ready_i=0 for 3 cycles
//    -> mult_en_o=0, req_ready_o=0, res_p_o/res_id_o held;
//       on release, resumes with no lost or duplicated results.
//  5 Operands a=b=8'hFF
//    -> res_p_o=16'hFE01 (full-width unsigned product).
//  6 Assert reset_n_i=0 mid-stream with 2 ops in flight
//    -> res_v_o and busy_o drop immediately; after release, first grant goes to req0.

Source files
------------

// File: rtl/qcl_mult_arbiter.sv
// qcl_mult_arbiter
//   Shares one pipelined multiplier among num_req_p requesters. A
//   combinational round-robin arbiter picks one operand pair per cycle and
//   drives the multiplier. A {valid, id} tag pipe runs in lockstep with the
//   multiplier so each product leaves tagged with the requester that issued it.
//   A stalled result freezes the whole pipe. Empty stages are not collapsed.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   req_v_i/req_a_i/req_b_i   per-requester valid and operands (packed, i*width_p)
//   req_ready_o               one-hot grant, qualified by mult_en_o
//   mult_en_o/a_o/b_o         drive the multiplier (en advances its pipeline)
//   mult_p_i                  product from the multiplier
//   res_v_o/p_o/id_o          tagged result channel
//   res_ready_i               result consumer ready
//   busy_o                    any valid operation inside the pipe
module qcl_mult_arbiter #(
    parameter int width_p   = 8,
    parameter int num_req_p = 4,
    parameter int latency_p = 2,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*width_p-1:0]   req_a_i,
    input  logic [num_req_p*width_p-1:0]   req_b_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic                           mult_en_o,
    output logic [width_p-1:0]             mult_a_o,
    output logic [width_p-1:0]             mult_b_o,
    input  logic [2*width_p-1:0]           mult_p_i,
    output logic                           res_v_o,
    output logic [2*width_p-1:0]           res_p_o,
    output logic [id_width_lp-1:0]         res_id_o,
    input  logic                           res_ready_i,
    output logic                           busy_o
);

    generate
        if (latency_p < 1 || latency_p > 4) begin : g_bad_latency
            $fatal(1, "qcl_mult_arbiter: latency_p must be in 1..4");
        end
    endgenerate

    logic [latency_p-1:0]                  vld_pipe;
    logic [latency_p-1:0][id_width_lp-1:0] id_pipe;
    logic [id_width_lp-1:0]                rr_ptr;

    logic                   any_req;
    logic [id_width_lp-1:0] winner;
    logic [width_p-1:0]     a_sel;
    logic [width_p-1:0]     b_sel;
    logic                   stall;
    int                     idx;

    assign res_v_o  = vld_pipe[latency_p-1];
    assign res_id_o = id_pipe[latency_p-1];
    assign res_p_o  = mult_p_i;
    assign busy_o   = |vld_pipe;

    // A stall holds the multiplier too, so res_p_o stays stable with the tag.
    assign stall     = res_v_o & ~res_ready_i;
    assign mult_en_o = reset_n_i & ~stall;

    // Scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        a_sel   = '0;
        b_sel   = '0;
        idx     = 0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = (int'(rr_ptr) + k) % num_req_p;
            if (!any_req && req_v_i[idx]) begin
                any_req = 1'b1;
                winner  = id_width_lp'(idx);
                a_sel   = req_a_i[idx*width_p +: width_p];
                b_sel   = req_b_i[idx*width_p +: width_p];
            end
        end
    end

    assign mult_a_o = a_sel;
    assign mult_b_o = b_sel;

    always_comb begin
        req_ready_o = '0;
        if (mult_en_o && any_req)
            req_ready_o[winner] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            rr_ptr   <= '0;
        end else if (mult_en_o) begin
            for (int i = latency_p - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
            vld_pipe[0] <= any_req;
            id_pipe[0]  <= winner;
            if (any_req)
                rr_ptr <= (winner == id_width_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: tb/tb_qcl_mult_arbiter.sv
module tb_qcl_mult_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int L   = 2;
    localparam int IDW = 2;

    logic             clk_i = 1'b0;
    logic             reset_n_i = 1'b0;
    logic [N-1:0]     req_v_i = '0;
    logic [N*W-1:0]   req_a_i = '0;
    logic [N*W-1:0]   req_b_i = '0;
    logic [N-1:0]     req_ready_o;
    logic             mult_en_o;
    logic [W-1:0]     mult_a_o, mult_b_o;
    logic [2*W-1:0]   mult_p_i;
    logic             res_v_o;
    logic [2*W-1:0]   res_p_o;
    logic [IDW-1:0]   res_id_o;
    logic             res_ready_i = 1'b1;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    qcl_mult_arbiter #(.width_p(W), .num_req_p(N), .latency_p(L)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_ready_o(req_ready_o),
        .mult_en_o(mult_en_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
        .mult_p_i(mult_p_i),
        .res_v_o(res_v_o), .res_p_o(res_p_o), .res_id_o(res_id_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o)
    );

    // Stand-in for the multiplier: L-stage pipeline advanced by en.
    logic [2*W-1:0] mpipe [L];
    always @(posedge clk_i) begin
        if (mult_en_o) begin
            mpipe[0] <= {8'b0, mult_a_o} * {8'b0, mult_b_o};
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mult_p_i = mpipe[L-1];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight products in issue order; each becomes
    // visible once L enabled cycles have elapsed since its issue.
    typedef struct { int id; logic [2*W-1:0] p; longint due; } txn_t;
    txn_t   q[$];
    int     ptr = 0;
    longint ecnt = 0;

    function automatic int m_winner();
        for (int k = 0; k < N; k++)
            if (req_v_i[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic bit m_resv();
        return (q.size() > 0) && (q[0].due == ecnt);
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or negedge reset_n_i);
            if (!reset_n_i) begin
                q.delete();
                ptr  = 0;
                ecnt = 0;
            end else begin
                bit v;
                int w;
                v = m_resv();
                if (!(v && !res_ready_i)) begin
                    if (v) void'(q.pop_front());
                    w = m_winner();
                    if (w >= 0) begin
                        txn_t t;
                        t.id  = w;
                        t.p   = {8'b0, req_a_i[w*W +: W]} * {8'b0, req_b_i[w*W +: W]};
                        t.due = ecnt + L;
                        q.push_back(t);
                        ptr = (w + 1) % N;
                    end
                    ecnt++;
                end
            end
        end
    end

    // Compare process: every negedge, DUT against the model.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            chk("rst_res_v", res_v_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_ready", req_ready_o, 0);
            chk("rst_en", mult_en_o, 0);
        end else begin
            bit v, en;
            int w;
            v  = m_resv();
            en = !(v && !res_ready_i);
            w  = m_winner();
            chk("res_v", res_v_o, v);
            if (v) begin
                chk("res_p", res_p_o, q[0].p);
                chk("res_id", res_id_o, q[0].id);
            end
            chk("mult_en", mult_en_o, en);
            chk("req_ready", req_ready_o, (en && w >= 0) ? (1 << w) : 0);
            chk("mult_a", mult_a_o, (w >= 0) ? req_a_i[w*W +: W] : 0);
            chk("mult_b", mult_b_o, (w >= 0) ? req_b_i[w*W +: W] : 0);
            chk("busy", busy_o, q.size() > 0);
        end
    end

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    initial begin
        // reset held for a few cycles
        repeat (3) step();
        reset_n_i = 1'b1;

        // req0 alone, 3*5, result after L cycles
        req_v_i = 4'b0001; req_a_i[0 +: W] = 8'd3; req_b_i[0 +: W] = 8'd5;
        @(negedge clk_i); chk("t1_grant", req_ready_o, 4'b0001);
        step(); req_v_i = '0;
        step(); @(negedge clk_i);
        chk("t1_v", res_v_o, 1); chk("t1_p", res_p_o, 15); chk("t1_id", res_id_o, 0);

        // full-width unsigned product from req2
        step(); req_v_i = 4'b0100; req_a_i[2*W +: W] = 8'hFF; req_b_i[2*W +: W] = 8'hFF;
        step(); req_v_i = '0;
        step(); @(negedge clk_i);
        chk("t5_p", res_p_o, 16'hFE01); chk("t5_id", res_id_o, 2);

        // pointer to 2 via req1, then req1|req3 -> 3 first, then 1
        step(); req_v_i = 4'b0010;
        step(); req_v_i = 4'b1010;
        @(negedge clk_i); chk("t3_first", req_ready_o, 4'b1000);
        step(); @(negedge clk_i); chk("t3_second", req_ready_o, 4'b0010);
        step(); req_v_i = '0;

        // fill pipe then stall 3 cycles
        req_v_i = 4'b1111; req_a_i = 32'h0403_0201; req_b_i = 32'h0807_0605;
        repeat (3) step();
        res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t4_en", mult_en_o, 0); chk("t4_ready", req_ready_o, 0); chk("t4_v", res_v_o, 1);
            step();
        end
        res_ready_i = 1'b1;
        repeat (3) step();
        req_v_i = '0;
        repeat (L + 1) step();
        @(negedge clk_i); chk("t4_drained", busy_o, 0);

        // reset with two ops in flight
        step(); req_v_i = 4'b0001;
        step(); step(); req_v_i = '0;
        @(negedge clk_i); chk("t6_busy_pre", busy_o, 1);
        @(posedge clk_i); #2 reset_n_i = 1'b0;
        #1 chk("t6_v_drop", res_v_o, 0); chk("t6_busy_drop", busy_o, 0);
        step(); step();
        reset_n_i = 1'b1; req_v_i = 4'b1111;
        // all valid continuously: grants 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i); chk("t2_grant", req_ready_o, 1 << (k % N));
            step();
        end
        req_v_i = '0;

        // randomized traffic with random backpressure
        for (int k = 0; k < 500; k++) begin
            req_v_i     = N'($urandom);
            req_a_i     = $urandom;
            req_b_i     = $urandom;
            res_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        req_v_i = '0; res_ready_i = 1'b1;
        repeat (L + 2) step();
        @(negedge clk_i); chk("final_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
